// File: rtl/r22sdf_stage.sv
`default_nettype none
//============================================================================
// r22sdf_stage : one radix-2^2 single-path delay-feedback FFT stage
//   (BF-I, trivial -j rotation, BF-II) of span L = N_POINTS / 4^STAGE.
// Option macro : R22_STAGE_SCALE_EN (each butterfly result >>> 1).
// Revision     : 1.0
//============================================================================
module r22sdf_stage #(
  parameter int DATA_WIDTH = 16,
  parameter int N_POINTS   = 16,
  parameter int STAGE      = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic                         in_sof,
  input  logic signed [DATA_WIDTH-1:0] a_re,
  input  logic signed [DATA_WIDTH-1:0] a_im,
  output logic                         out_valid,
  output logic                         out_sof,
  output logic signed [DATA_WIDTH-1:0] b_re,
  output logic signed [DATA_WIDTH-1:0] b_im
);

  localparam int c_span = N_POINTS >> (2 * STAGE);
  localparam int c_k    = (c_span >= 4) ? $clog2(c_span) : 2;
  localparam int c_d1   = (1 << c_k) / 2;
  localparam int c_d2   = (1 << c_k) / 4;
  localparam logic [c_k-1:0] c_first_out = c_k'(3 * (1 << c_k) / 4);

  generate
    if (c_span < 4) begin : g_bad_span
      $error("r22sdf_stage: N_POINTS/4^STAGE must be at least 4");
    end
    if (N_POINTS < 16 || N_POINTS > 4096 || ($clog2(N_POINTS) % 2) != 0 ||
        (1 << $clog2(N_POINTS)) != N_POINTS) begin : g_bad_n
      $error("r22sdf_stage: N_POINTS must be a power of 4 in 16..4096");
    end
  endgenerate

  // Add or subtract at DATA_WIDTH+1 bits, then scale or wrap back to DATA_WIDTH.
  function automatic logic signed [DATA_WIDTH-1:0] bfly(
    input logic signed [DATA_WIDTH-1:0] x,
    input logic signed [DATA_WIDTH-1:0] y,
    input logic                         sub
  );
    logic signed [DATA_WIDTH:0] s;
    s = sub ? ({x[DATA_WIDTH-1], x} - {y[DATA_WIDTH-1], y})
            : ({x[DATA_WIDTH-1], x} + {y[DATA_WIDTH-1], y});
`ifdef R22_STAGE_SCALE_EN
    return DATA_WIDTH'(s >>> 1);
`else
    return DATA_WIDTH'(s);
`endif
  endfunction

  logic [c_k-1:0] cnt_q, cnt_d, w_idx, w_aidx;
  logic           sof_seen_q, primed_q, w_primed;
  logic           out_valid_q, out_sof_q;
  logic signed [DATA_WIDTH-1:0] b_re_q, b_im_q;

  // Sample index of the current input; BF-II sees the stream L/2 samples later.
  assign w_idx  = in_sof ? '0 : cnt_q;
  assign w_aidx = {~w_idx[c_k-1], w_idx[c_k-2:0]};
  assign cnt_d  = w_idx + c_k'(1);

  logic signed [DATA_WIDTH-1:0] d1_re_q [c_d1];
  logic signed [DATA_WIDTH-1:0] d1_im_q [c_d1];
  logic signed [DATA_WIDTH-1:0] d2_re_q [c_d2];
  logic signed [DATA_WIDTH-1:0] d2_im_q [c_d2];
  logic signed [DATA_WIDTH-1:0] w_h1_re, w_h1_im, w_h2_re, w_h2_im;
  logic signed [DATA_WIDTH-1:0] w_y_re, w_y_im, w_s1_re, w_s1_im;
  logic signed [DATA_WIDTH-1:0] w_z_re, w_z_im;
  logic signed [DATA_WIDTH-1:0] w_o_re, w_o_im, w_s2_re, w_s2_im;

  assign w_h1_re = d1_re_q[c_d1-1];
  assign w_h1_im = d1_im_q[c_d1-1];
  assign w_h2_re = d2_re_q[c_d2-1];
  assign w_h2_im = d2_im_q[c_d2-1];

  always_comb begin
    w_y_re  = w_h1_re;
    w_y_im  = w_h1_im;
    w_s1_re = a_re;
    w_s1_im = a_im;
    if (w_idx[c_k-1]) begin
      w_y_re  = bfly(w_h1_re, a_re, 1'b0);
      w_y_im  = bfly(w_h1_im, a_im, 1'b0);
      w_s1_re = bfly(w_h1_re, a_re, 1'b1);
      w_s1_im = bfly(w_h1_im, a_im, 1'b1);
    end
  end

  always_comb begin
    w_z_re = w_y_re;
    w_z_im = w_y_im;
    if (w_aidx[c_k-1] && !w_aidx[c_k-2]) begin
      w_z_re = w_y_im;
      w_z_im = -w_y_re;
    end
  end

  always_comb begin
    w_o_re  = w_h2_re;
    w_o_im  = w_h2_im;
    w_s2_re = w_z_re;
    w_s2_im = w_z_im;
    if (w_aidx[c_k-2]) begin
      w_o_re  = bfly(w_h2_re, w_z_re, 1'b0);
      w_o_im  = bfly(w_h2_im, w_z_im, 1'b0);
      w_s2_re = bfly(w_h2_re, w_z_re, 1'b1);
      w_s2_im = bfly(w_h2_im, w_z_im, 1'b1);
    end
  end

  // Delay lines carry no reset so they can map onto shift-register primitives.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      d1_re_q[0] <= w_s1_re;
      d1_im_q[0] <= w_s1_im;
      for (int i = 1; i < c_d1; i++) begin
        d1_re_q[i] <= d1_re_q[i-1];
        d1_im_q[i] <= d1_im_q[i-1];
      end
      d2_re_q[0] <= w_s2_re;
      d2_im_q[0] <= w_s2_im;
      for (int i = 1; i < c_d2; i++) begin
        d2_re_q[i] <= d2_re_q[i-1];
        d2_im_q[i] <= d2_im_q[i-1];
      end
    end
  end

  // Outputs start only once a frame seen since reset reaches index 3L/4.
  assign w_primed = primed_q | ((sof_seen_q | in_sof) & (w_idx == c_first_out));

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q       <= '0;
      sof_seen_q  <= 1'b0;
      primed_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      b_re_q      <= '0;
      b_im_q      <= '0;
    end else if (in_valid) begin
      cnt_q       <= cnt_d;
      sof_seen_q  <= sof_seen_q | in_sof;
      primed_q    <= w_primed;
      out_valid_q <= w_primed;
      out_sof_q   <= w_primed & (w_idx == c_first_out);
      b_re_q      <= w_o_re;
      b_im_q      <= w_o_im;
    end else begin
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sof   = out_sof_q;
  assign b_re      = b_re_q;
  assign b_im      = b_im_q;

endmodule
`default_nettype wire

// File: tb/tb_r22sdf_stage.sv
`default_nettype none
//============================================================================
// tb_r22sdf_stage : directed self-checking bench for r22sdf_stage
//   (L=16 via N=16/STAGE=0 and N=64/STAGE=1 instances, shared stimulus).
// Revision        : 1.0
//============================================================================
module tb_r22sdf_stage;

  localparam int DW = 16;
`ifdef R22_STAGE_SCALE_EN
  localparam int C_CONST = 100;
  localparam int C_IMP   = 250;
`else
  localparam int C_CONST = 400;
  localparam int C_IMP   = 1000;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, in_valid, in_sof;
  logic signed [DW-1:0] a_re, a_im;
  logic out_valid, out_sof, out_valid64, out_sof64;
  logic signed [DW-1:0] b_re, b_im, b_re64, b_im64;

  r22sdf_stage #(.DATA_WIDTH(DW), .N_POINTS(16), .STAGE(0)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof),
    .a_re(a_re), .a_im(a_im), .out_valid(out_valid), .out_sof(out_sof),
    .b_re(b_re), .b_im(b_im)
  );

  r22sdf_stage #(.DATA_WIDTH(DW), .N_POINTS(64), .STAGE(1)) u_dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof),
    .a_re(a_re), .a_im(a_im), .out_valid(out_valid64), .out_sof(out_sof64),
    .b_re(b_re64), .b_im(b_im64)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  int o_re [64], o_im [64], o64_re [64], o64_im [64];
  bit o_sof [64];
  int n_in, n_out, n_out64, first_at, idle_valid, idle_chg, prev_re, prev_im;
  int sof64_pos [$];
  int x_re [16], x_im [16], e_re [16], e_im [16];

  task automatic clr();
    n_in = 0; n_out = 0; n_out64 = 0; first_at = -1;
    idle_valid = 0; idle_chg = 0;
    sof64_pos.delete();
    for (int i = 0; i < 64; i++) begin
      o_re[i] = 32'h7fffffff; o_im[i] = 32'h7fffffff; o_sof[i] = 1'b0;
      o64_re[i] = 32'h7fffffff; o64_im[i] = 32'h7fffffff;
    end
  endtask

  // One clock: drive, let the edge pass, sample outputs on the falling edge.
  task automatic cyc(input bit v, input bit s, input int re, input int im);
    in_valid = v; in_sof = s; a_re = DW'(re); a_im = DW'(im);
    @(posedge clk);
    if (v && rst) n_in++;
    @(negedge clk);
    if (out_valid) begin
      if (first_at < 0) first_at = n_in;
      if (n_out < 64) begin
        o_re[n_out] = b_re; o_im[n_out] = b_im; o_sof[n_out] = out_sof;
      end
      n_out++;
    end
    if (out_valid64) begin
      if (out_sof64) sof64_pos.push_back(n_out64);
      if (n_out64 < 64) begin
        o64_re[n_out64] = b_re64; o64_im[n_out64] = b_im64;
      end
      n_out64++;
    end
    if (!v) begin
      if (out_valid) idle_valid++;
      if (b_re != prev_re || b_im != prev_im) idle_chg++;
    end
    prev_re = b_re; prev_im = b_im;
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    repeat (2) cyc(0, 0, 0, 0);
    rst = 1'b1;
    clr();
  endtask

  function automatic int wrap(input int v);
    logic signed [DW-1:0] t;
    t = DW'(v);
    return int'(t);
  endfunction

  function automatic int red(input int v);
`ifdef R22_STAGE_SCALE_EN
    return v >>> 1;
`else
    return wrap(v);
`endif
  endfunction

  // Radix-4 reference: X0=a+b+c+d, X1=a-b+c-d, X2/X3 = -j(a-c) +/- (b-d).
  task automatic model();
    for (int n = 0; n < 4; n++) begin
      int y0r, y0i, y1r, y1i, y2r, y2i, y3r, y3i, z2r, z2i;
      y0r = red(x_re[n] + x_re[n+8]);   y0i = red(x_im[n] + x_im[n+8]);
      y1r = red(x_re[n+4] + x_re[n+12]); y1i = red(x_im[n+4] + x_im[n+12]);
      y2r = red(x_re[n] - x_re[n+8]);   y2i = red(x_im[n] - x_im[n+8]);
      y3r = red(x_re[n+4] - x_re[n+12]); y3i = red(x_im[n+4] - x_im[n+12]);
      z2r = y2i; z2i = wrap(-y2r);
      e_re[n]    = red(y0r + y1r); e_im[n]    = red(y0i + y1i);
      e_re[n+4]  = red(y0r - y1r); e_im[n+4]  = red(y0i - y1i);
      e_re[n+8]  = red(z2r + y3r); e_im[n+8]  = red(z2i + y3i);
      e_re[n+12] = red(z2r - y3r); e_im[n+12] = red(z2i - y3i);
    end
  endtask

  task automatic set_x(input bit ramp, input int re, input int im);
    for (int i = 0; i < 16; i++) begin
      x_re[i] = ramp ? 100 * i - 700 : re;
      x_im[i] = ramp ? 50 - 30 * i   : im;
    end
  endtask

  task automatic run_frame(input bit gaps);
    for (int i = 0; i < 28; i++) begin
      if (i < 16) cyc(1, i == 0, x_re[i], x_im[i]);
      else        cyc(1, i == 16, 0, 0);
      if (gaps) begin cyc(0, 0, 0, 0); cyc(0, 0, 0, 0); end
    end
    repeat (3) cyc(0, 0, 0, 0);
  endtask

  task automatic check_frame(input string tag);
    int extra;
    extra = 0;
    chk({tag, " count"}, n_out, 16);
    chk({tag, " latency"}, first_at, 13);
    chk({tag, " sof0"}, 32'(o_sof[0]), 1);
    for (int i = 1; i < 16; i++) extra += int'(o_sof[i]);
    chk({tag, " sof extra"}, extra, 0);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("%s re[%0d]", tag, i), o_re[i], e_re[i]);
      chk($sformatf("%s im[%0d]", tag, i), o_im[i], e_im[i]);
    end
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_sof = 1'b0; a_re = '0; a_im = '0;
    prev_re = 0; prev_im = 0;
    clr();
    repeat (3) cyc(0, 0, 0, 0);
    chk("reset out_valid", 32'(out_valid), 0);
    chk("reset out_sof", 32'(out_sof), 0);
    chk("reset b_re", b_re, 0);
    chk("reset b_im", b_im, 0);
    rst = 1'b1;
    clr();

    // Constant 100+0j
    set_x(0, 100, 0);
    for (int i = 0; i < 16; i++) begin e_re[i] = (i < 4) ? C_CONST : 0; e_im[i] = 0; end
    run_frame(0);
    check_frame("const");

    // Impulse 1000+0j at index 0
    reset_dut();
    set_x(0, 0, 0); x_re[0] = 1000;
    for (int i = 0; i < 16; i++) begin e_re[i] = 0; e_im[i] = 0; end
    e_re[0] = C_IMP; e_re[4] = C_IMP; e_im[8] = -C_IMP; e_im[12] = -C_IMP;
    run_frame(0);
    check_frame("impulse");

    // Near full scale: unscaled sums wrap modulo 2^16
    reset_dut();
    set_x(0, 20000, -20000); model();
    run_frame(0);
    check_frame("ovf");

    // Ramp, then reset asserted at index 7 of the next frame
    reset_dut();
    set_x(1, 0, 0); model();
    run_frame(0);
    check_frame("ramp");
    for (int i = 0; i < 7; i++) cyc(1, i == 0, 100, 0);
    rst = 1'b0;
    cyc(1, 0, 100, 0);
    chk("midrst out_valid", 32'(out_valid), 0);
    chk("midrst out_sof", 32'(out_sof), 0);
    chk("midrst b_re", b_re, 0);
    chk("midrst b_im", b_im, 0);
    rst = 1'b1;
    clr();
    set_x(0, 100, 0);
    for (int i = 0; i < 16; i++) begin e_re[i] = (i < 4) ? C_CONST : 0; e_im[i] = 0; end
    run_frame(0);
    check_frame("midrst");

    // Constant with in_valid pattern 1,0,0
    reset_dut();
    run_frame(1);
    check_frame("gaps");
    chk("gaps idle valid", idle_valid, 0);
    chk("gaps idle hold", idle_chg, 0);

    // Three back-to-back ramp frames
    reset_dut();
    set_x(1, 0, 0); model();
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < 16; i++) cyc(1, i == 0, x_re[i], x_im[i]);
    repeat (2) cyc(0, 0, 0, 0);
    chk("b2b n64 outputs", n_out64, 36);
    chk("b2b n16 outputs", n_out, 36);
    chk("b2b sof count", sof64_pos.size(), 3);
    chk("b2b sof0 pos", (sof64_pos.size() > 0) ? sof64_pos[0] : -1, 0);
    chk("b2b sof1 pos", (sof64_pos.size() > 1) ? sof64_pos[1] : -1, 16);
    chk("b2b sof2 pos", (sof64_pos.size() > 2) ? sof64_pos[2] : -1, 32);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("b2b f2 re[%0d]", i), o64_re[16+i], e_re[i]);
      chk($sformatf("b2b f2 im[%0d]", i), o64_im[16+i], e_im[i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
